// File: rtl/vfm_io_pkg.sv
// Shared constants and helpers for the VFM output-port arbiter family.
package vfm_io_pkg;

   localparam int VFM_DW       = 14;
   localparam int VFM_NREQ_MAX = 8;

   localparam logic [VFM_DW-1:0] VFM_OUT_RST = '0;

   // Index width for n sources; never returns less than 1 bit.
   function automatic int clog2(input int n);
      int r;
      r = 1;
      for (int i = 1; i < 32; i++)
         if ((1 << i) < n) r = i + 1;
      return r;
   endfunction

endpackage

// File: rtl/vfm_rr_pick.sv
// Combinational round-robin picker: first set req bit searching circularly from ptr.
module vfm_rr_pick #(
   parameter int NREQ = 4,
   parameter int SRCW = 2
) (
   input  logic [NREQ-1:0] req,
   input  logic [SRCW-1:0] ptr,
   output logic            gnt_valid,
   output logic [SRCW-1:0] gnt_idx
);

   localparam int SW1 = SRCW + 1;

   logic [2*NREQ-1:0] w_dbl;
   logic [NREQ-1:0]   w_rot;
   logic [SRCW-1:0]   w_off;
   logic [SRCW:0]     w_sum;

   // Doubling req makes the right shift a rotation as long as ptr < NREQ.
   assign w_dbl = {req, req} >> ptr;
   assign w_rot = w_dbl[NREQ-1:0];

   always_comb begin
      gnt_valid = 1'b0;
      w_off     = '0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         if (w_rot[i]) begin
            gnt_valid = 1'b1;
            w_off     = SRCW'(i);
         end
      end
   end

   assign w_sum   = {1'b0, ptr} + {1'b0, w_off};
   assign gnt_idx = (w_sum >= SW1'(NREQ)) ? SRCW'(w_sum - SW1'(NREQ)) : SRCW'(w_sum);

endmodule

// File: rtl/vfm_outport_arbiter.sv
// Shares one output register between NREQ writers via one-entry holds and a
// round-robin commit of one word per clock.
module vfm_outport_arbiter
   import vfm_io_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int DW   = VFM_DW,
   parameter int SRCW = clog2(NREQ)
) (
   input  logic              Clock_pin,
   input  logic              Resetn_pin,
   input  logic              enable,
   input  logic [NREQ-1:0]   wr_strobe,
   input  logic [NREQ*DW-1:0] wr_data,
   input  logic [NREQ-1:0]   ovf_clr,
   output logic [NREQ-1:0]   ack,
   output logic [NREQ-1:0]   pending,
   output logic [NREQ-1:0]   ovf,
   output logic [DW-1:0]     out_data,
   output logic [SRCW-1:0]   out_src,
   output logic              out_valid
);

   logic [NREQ-1:0][DW-1:0] r_hold;
   logic [NREQ-1:0]         r_pending;
   logic [NREQ-1:0]         r_ovf;
   logic [NREQ-1:0]         r_ack;
   logic [DW-1:0]           r_out_data;
   logic [SRCW-1:0]         r_out_src;
   logic                    r_out_valid;
   logic [SRCW-1:0]         r_ptr;

   logic                    w_pick_valid;
   logic [SRCW-1:0]         w_gnt_idx;
   logic                    w_grant;
   logic [NREQ-1:0]         w_gnt_oh;

   // Only registered pending is eligible; a same-cycle strobe waits a cycle.
   vfm_rr_pick #(.NREQ(NREQ), .SRCW(SRCW)) u_pick (
      .req       (r_pending),
      .ptr       (r_ptr),
      .gnt_valid (w_pick_valid),
      .gnt_idx   (w_gnt_idx)
   );

   assign w_grant = enable & w_pick_valid;

   always_comb begin
      w_gnt_oh = '0;
      for (int i = 0; i < NREQ; i++)
         w_gnt_oh[i] = w_grant && (w_gnt_idx == SRCW'(i));
   end

   always_ff @(posedge Clock_pin or negedge Resetn_pin) begin
      if (!Resetn_pin) begin
         r_hold      <= '0;
         r_pending   <= '0;
         r_ovf       <= '0;
         r_ack       <= '0;
         r_out_data  <= DW'(VFM_OUT_RST);
         r_out_src   <= '0;
         r_out_valid <= 1'b0;
         r_ptr       <= '0;
      end else begin
         r_out_valid <= w_grant;
         r_ack       <= w_gnt_oh;
         if (w_grant) begin
            r_out_data <= r_hold[w_gnt_idx];
            r_out_src  <= w_gnt_idx;
            r_ptr      <= (w_gnt_idx == SRCW'(NREQ - 1)) ? '0 : w_gnt_idx + 1'b1;
         end
         for (int i = 0; i < NREQ; i++) begin
            if (wr_strobe[i])
               r_hold[i] <= wr_data[i*DW +: DW];
            // A strobe on the lane being granted refills it: old word out, new word held.
            if (wr_strobe[i])
               r_pending[i] <= 1'b1;
            else if (w_gnt_oh[i])
               r_pending[i] <= 1'b0;
            if (wr_strobe[i] && r_pending[i] && !w_gnt_oh[i])
               r_ovf[i] <= 1'b1;
            else if (ovf_clr[i])
               r_ovf[i] <= 1'b0;
         end
      end
   end

   assign ack       = r_ack;
   assign pending   = r_pending;
   assign ovf       = r_ovf;
   assign out_data  = r_out_data;
   assign out_src   = r_out_src;
   assign out_valid = r_out_valid;

endmodule

// File: tb/tb_vfm_outport_arbiter.sv
// Directed bench for vfm_outport_arbiter with hand-computed expectations.
module tb_vfm_outport_arbiter;

   localparam int NREQ = 4;
   localparam int DW   = 14;
   localparam int SRCW = 2;

   logic              Clock_pin;
   logic              Resetn_pin;
   logic              enable;
   logic [NREQ-1:0]   wr_strobe;
   logic [NREQ*DW-1:0] wr_data;
   logic [NREQ-1:0]   ovf_clr;
   logic [NREQ-1:0]   ack;
   logic [NREQ-1:0]   pending;
   logic [NREQ-1:0]   ovf;
   logic [DW-1:0]     out_data;
   logic [SRCW-1:0]   out_src;
   logic              out_valid;

   int checks;
   int failures;

   vfm_outport_arbiter #(.NREQ(NREQ), .DW(DW), .SRCW(SRCW)) dut (
      .Clock_pin  (Clock_pin),
      .Resetn_pin (Resetn_pin),
      .enable     (enable),
      .wr_strobe  (wr_strobe),
      .wr_data    (wr_data),
      .ovf_clr    (ovf_clr),
      .ack        (ack),
      .pending    (pending),
      .ovf        (ovf),
      .out_data   (out_data),
      .out_src    (out_src),
      .out_valid  (out_valid)
   );

   initial Clock_pin = 1'b0;
   always #5 Clock_pin = ~Clock_pin;

   task automatic cyc();
      @(posedge Clock_pin);
      #1;
   endtask

   task automatic set_data(input int i, input logic [DW-1:0] d);
      wr_data[i*DW +: DW] = d;
   endtask

   task automatic test_reset();
      Resetn_pin = 1'b0; enable = 1'b0; wr_strobe = '0; wr_data = '0; ovf_clr = '0;
      repeat (2) cyc();
      Resetn_pin = 1'b1;
      cyc();
      checks++;
      if (out_data !== 14'h0 || out_src !== 2'd0 || out_valid !== 1'b0 ||
          ack !== 4'b0 || pending !== 4'b0 || ovf !== 4'b0) begin
         failures++;
         $display("FAIL reset_init: data=%h src=%0d valid=%b ack=%b pend=%b ovf=%b, want all zero",
                  out_data, out_src, out_valid, ack, pending, ovf);
      end
      // Advance ptr away from 0 so the later fairness order proves reset clears it.
      enable = 1'b1; wr_strobe = 4'b0010; set_data(1, 14'h0AA);
      cyc();
      wr_strobe = '0;
      cyc();
      checks++;
      if (out_valid !== 1'b1 || out_src !== 2'd1 || out_data !== 14'h0AA) begin
         failures++;
         $display("FAIL reset_precommit: valid=%b src=%0d data=%h, want 1 1 0aa", out_valid, out_src, out_data);
      end
      enable = 1'b0; wr_strobe = 4'b1010; set_data(1, 14'h111); set_data(3, 14'h333);
      cyc();
      wr_strobe = '0;
      checks++;
      if (pending !== 4'b1010) begin
         failures++;
         $display("FAIL reset_pending_setup: pending=%b want 1010", pending);
      end
      #3 Resetn_pin = 1'b0;
      #1;
      checks++;
      if (out_data !== 14'h0 || out_src !== 2'd0 || out_valid !== 1'b0 ||
          ack !== 4'b0 || pending !== 4'b0 || ovf !== 4'b0) begin
         failures++;
         $display("FAIL reset_async: data=%h src=%0d valid=%b ack=%b pend=%b ovf=%b, want all zero",
                  out_data, out_src, out_valid, ack, pending, ovf);
      end
      cyc();
      Resetn_pin = 1'b1; enable = 1'b1;
      for (int k = 0; k < 3; k++) begin
         cyc();
         checks++;
         if (ack !== 4'b0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_no_ack[%0d]: ack=%b valid=%b, want 0000 0", k, ack, out_valid);
         end
      end
   endtask

   task automatic test_fairness();
      for (int r = 0; r < 2; r++) begin
         wr_strobe = 4'b1111;
         for (int i = 0; i < NREQ; i++) set_data(i, DW'(r*4 + i + 1));
         cyc();
         wr_strobe = '0;
         for (int i = 0; i < NREQ; i++) begin
            cyc();
            checks++;
            if (out_valid !== 1'b1 || out_src !== SRCW'(i) || out_data !== DW'(r*4 + i + 1) ||
                ack !== (4'b0001 << i)) begin
               failures++;
               $display("FAIL fair_r%0d_c%0d: valid=%b src=%0d data=%h ack=%b, want 1 %0d %h %b",
                        r, i, out_valid, out_src, out_data, ack, i, r*4 + i + 1, 4'b0001 << i);
            end
         end
         cyc();
         checks++;
         if (out_valid !== 1'b0 || ack !== 4'b0 || pending !== 4'b0 || out_data !== DW'(r*4 + 4)) begin
            failures++;
            $display("FAIL fair_idle_r%0d: valid=%b ack=%b pend=%b data=%h, want 0 0000 0000 %h",
                     r, out_valid, ack, pending, out_data, r*4 + 4);
         end
      end
   endtask

   task automatic test_single();
      wr_strobe = 4'b0100; set_data(2, 14'h1A5);
      cyc();
      wr_strobe = '0;
      checks++;
      if (pending !== 4'b0100 || out_valid !== 1'b0) begin
         failures++;
         $display("FAIL single_capture: pending=%b valid=%b, want 0100 0", pending, out_valid);
      end
      cyc();
      checks++;
      if (out_data !== 14'h1A5 || out_src !== 2'd2 || out_valid !== 1'b1 ||
          ack !== 4'b0100 || pending !== 4'b0) begin
         failures++;
         $display("FAIL single_commit: data=%h src=%0d valid=%b ack=%b pend=%b, want 1a5 2 1 0100 0000",
                  out_data, out_src, out_valid, ack, pending);
      end
      cyc();
      checks++;
      if (out_valid !== 1'b0 || ack !== 4'b0 || out_data !== 14'h1A5 || out_src !== 2'd2) begin
         failures++;
         $display("FAIL single_hold: valid=%b ack=%b data=%h src=%0d, want 0 0000 1a5 2",
                  out_valid, ack, out_data, out_src);
      end
   endtask

   task automatic test_overflow();
      enable = 1'b0;
      wr_strobe = 4'b0010; set_data(1, 14'h011);
      cyc();
      // Overflow and clear on the same edge: overflow must win.
      set_data(1, 14'h022); ovf_clr = 4'b0010;
      cyc();
      wr_strobe = '0; ovf_clr = '0;
      checks++;
      if (ovf !== 4'b0010 || pending !== 4'b0010 || out_valid !== 1'b0) begin
         failures++;
         $display("FAIL ovf_set: ovf=%b pend=%b valid=%b, want 0010 0010 0", ovf, pending, out_valid);
      end
      enable = 1'b1;
      cyc();
      checks++;
      if (out_valid !== 1'b1 || out_data !== 14'h022 || out_src !== 2'd1 || ack !== 4'b0010) begin
         failures++;
         $display("FAIL ovf_commit: valid=%b data=%h src=%0d ack=%b, want 1 022 1 0010",
                  out_valid, out_data, out_src, ack);
      end
      cyc();
      checks++;
      if (out_valid !== 1'b0 || ovf !== 4'b0010) begin
         failures++;
         $display("FAIL ovf_single: valid=%b ovf=%b, want 0 0010", out_valid, ovf);
      end
      ovf_clr = 4'b0010;
      cyc();
      ovf_clr = '0;
      checks++;
      if (ovf !== 4'b0) begin
         failures++;
         $display("FAIL ovf_clear: ovf=%b want 0000", ovf);
      end
   endtask

   task automatic test_collision();
      enable = 1'b1;
      wr_strobe = 4'b1000; set_data(3, 14'h100);
      cyc();
      set_data(3, 14'h200);
      cyc();
      wr_strobe = '0;
      checks++;
      if (out_valid !== 1'b1 || out_data !== 14'h100 || out_src !== 2'd3 ||
          pending !== 4'b1000 || ovf !== 4'b0) begin
         failures++;
         $display("FAIL coll_first: valid=%b data=%h src=%0d pend=%b ovf=%b, want 1 100 3 1000 0000",
                  out_valid, out_data, out_src, pending, ovf);
      end
      cyc();
      checks++;
      if (out_valid !== 1'b1 || out_data !== 14'h200 || out_src !== 2'd3 ||
          pending !== 4'b0 || ovf !== 4'b0 || ack !== 4'b1000) begin
         failures++;
         $display("FAIL coll_second: valid=%b data=%h src=%0d pend=%b ovf=%b ack=%b, want 1 200 3 0000 0000 1000",
                  out_valid, out_data, out_src, pending, ovf, ack);
      end
   endtask

   task automatic test_enable();
      enable = 1'b0;
      wr_strobe = 4'b0001; set_data(0, 14'h03C);
      cyc();
      wr_strobe = '0;
      for (int k = 0; k < 5; k++) begin
         cyc();
         checks++;
         if (out_valid !== 1'b0 || pending !== 4'b0001) begin
            failures++;
            $display("FAIL en_gated[%0d]: valid=%b pend=%b, want 0 0001", k, out_valid, pending);
         end
      end
      enable = 1'b1;
      cyc();
      checks++;
      if (out_valid !== 1'b1 || out_data !== 14'h03C || out_src !== 2'd0 ||
          ack !== 4'b0001 || pending !== 4'b0) begin
         failures++;
         $display("FAIL en_release: valid=%b data=%h src=%0d ack=%b pend=%b, want 1 03c 0 0001 0000",
                  out_valid, out_data, out_src, ack, pending);
      end
   endtask

   initial begin
      checks = 0;
      failures = 0;
      test_reset();
      test_fairness();
      test_single();
      test_overflow();
      test_collision();
      test_enable();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
